// File: rtl/cheshire_uart_rx_sniffer.sv
// 8N1 UART receive monitor: deserializes frames from rx_i and buffers the
// completed bytes in a small FIFO drained over a valid/ready byte stream.
module cheshire_uart_rx_sniffer #(
    parameter int unsigned ClkDiv    = 434,
    parameter int unsigned FifoDepth = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       reading_byte_o,
    output logic       frame_err_o,
    output logic       overflow_o
);

    localparam int unsigned CntW = $clog2(ClkDiv);
    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam logic [CntW-1:0] HalfLoad = CntW'(ClkDiv / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(ClkDiv - 1);
    localparam logic [PtrW:0]   Depth    = (PtrW + 1)'(FifoDepth);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      data_q, data_d;
    logic            frame_err_d;
    logic            push;

    logic rx_meta, rx_s, rx_q;
    logic fall;

    logic [7:0]      mem [FifoDepth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [PtrW:0]   count_q;
    logic            pop, push_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    // Edge-qualified start: a line held low after a frame (break) never restarts.
    assign fall = rx_q & ~rx_s;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        data_d      = data_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    cnt_d   = HalfLoad;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (!rx_s) begin
                    cnt_d   = FullLoad;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    data_d[idx_q[2:0]] = rx_s;
                    cnt_d              = FullLoad;
                    idx_d              = idx_q + 4'd1;
                    if (idx_q == 4'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    push        = rx_s;
                    frame_err_d = ~rx_s;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            frame_err_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            frame_err_o <= frame_err_d;
        end
    end

    assign reading_byte_o = (state_q != IDLE);

    assign valid_o = (count_q != '0);
    assign byte_o  = mem[rptr_q];
    assign pop     = valid_o & ready_i;
    // A full FIFO still accepts a byte when the head is popped in the same cycle.
    assign push_ok = push & ((count_q < Depth) | pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < FifoDepth; i++) mem[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wptr_q] <= data_q;
                wptr_q      <= wptr_q + PtrW'(1);
            end
            if (pop) rptr_q <= rptr_q + PtrW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (push && !push_ok) overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cheshire_uart_rx_sniffer.sv
// Self-checking bench for cheshire_uart_rx_sniffer (ClkDiv=8, FifoDepth=4)
// using a byte scoreboard fed by the frame driver.
module tb_cheshire_uart_rx_sniffer;

    localparam int unsigned C = 8;
    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_i;
    logic       ready_i;
    logic [7:0] byte_o;
    logic       valid_o;
    logic       reading_byte_o;
    logic       frame_err_o;
    logic       overflow_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    cheshire_uart_rx_sniffer #(
        .ClkDiv   (C),
        .FifoDepth(D)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rx_i          (rx_i),
        .byte_o        (byte_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .reading_byte_o(reading_byte_o),
        .frame_err_o   (frame_err_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (rst_n && valid_o && ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got byte %02h, required no byte", byte_o);
            end else begin
                e = exp_q.pop_front();
                if (byte_o !== e) $display("FAIL sb_byte: got %02h, required %02h", byte_o, e);
                else n_pass++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_i = v;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit accept);
        if (stop && accept) exp_q.push_back(b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || valid_o) && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0 || valid_o)
            $display("FAIL drain: %0d bytes pending valid=%b, required 0 pending valid=0", exp_q.size(), valid_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({byte_o, valid_o, reading_byte_o, frame_err_o, overflow_o} !== 12'h000)
            $display("FAIL reset_outputs: got %03h, required 000",
                     {byte_o, valid_o, reading_byte_o, frame_err_o, overflow_o});
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) idle_sync();
        n_checks++;
        if ({valid_o, reading_byte_o, frame_err_o} !== 3'b000)
            $display("FAIL post_reset_idle: got %b, required 000", {valid_o, reading_byte_o, frame_err_o});
        else n_pass++;
    endtask

    task automatic test_single_frame();
        int first_rb = -1, last_rb = -1, first_v = -1, nv = 0;
        ready_i = 1'b1;
        idle_sync();
        fork
            send_frame(8'h5A, 1'b1, 1'b1);
            for (int k = 0; k < 84; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (reading_byte_o) begin
                    if (first_rb < 0) first_rb = k;
                    last_rb = k;
                end
                if (valid_o) begin
                    if (first_v < 0) first_v = k;
                    nv++;
                end
            end
        join
        n_checks++;
        if (first_rb != 2) $display("FAIL rb_rise: got cycle %0d, required 2", first_rb);
        else n_pass++;
        n_checks++;
        if (last_rb != 77) $display("FAIL rb_last: got cycle %0d, required 77", last_rb);
        else n_pass++;
        n_checks++;
        if (first_v + 1 != 79) $display("FAIL latency: got %0d cycles, required 79", first_v + 1);
        else n_pass++;
        n_checks++;
        if (nv != 1) $display("FAIL valid_pulse: got %0d cycles, required 1", nv);
        else n_pass++;
        idle_sync();
        wait_drain(10);
    endtask

    task automatic test_glitch();
        int nrb = 0, nfe = 0, nv = 0;
        idle_sync();
        rx_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) rx_i = 1'b1;
            @(negedge clk);
            if (reading_byte_o) nrb++;
            if (frame_err_o) nfe++;
            if (valid_o) nv++;
        end
        n_checks++;
        if (nrb != 4) $display("FAIL glitch_busy: got %0d cycles, required 4", nrb);
        else n_pass++;
        n_checks++;
        if (nfe != 0 || nv != 0) $display("FAIL glitch_output: got fe=%0d valid=%0d, required 0 0", nfe, nv);
        else n_pass++;
    endtask

    task automatic test_frame_error();
        int nfe = 0, nv = 0;
        ready_i = 1'b1;
        idle_sync();
        fork
            begin
                send_frame(8'hA5, 1'b0, 1'b0);
                drive_bit(1'b1);
            end
            for (int k = 0; k < 95; k++) begin
                @(negedge clk);
                if (frame_err_o) nfe++;
                if (valid_o) nv++;
            end
        join
        idle_sync();
        n_checks++;
        if (nfe != 1) $display("FAIL frame_err_pulse: got %0d pulses, required 1", nfe);
        else n_pass++;
        n_checks++;
        if (nv != 0) $display("FAIL frame_err_valid: got %0d valid cycles, required 0", nv);
        else n_pass++;
        send_frame(8'h3C, 1'b1, 1'b1);
        wait_drain(20);
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b1;
        idle_sync();
        for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
        wait_drain(20);
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        ready_i = 1'b0;
        idle_sync();
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1, 1'b1);
        end
        n_checks++;
        if ({overflow_o, valid_o} !== 2'b01)
            $display("FAIL ovf_before: got ovf=%b valid=%b, required 0 1", overflow_o, valid_o);
        else n_pass++;
        send_frame(8'h05, 1'b1, 1'b0);
        n_checks++;
        if (overflow_o !== 1'b1) $display("FAIL ovf_set: got %b, required 1", overflow_o);
        else n_pass++;
        ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (valid_o !== (k < 4)) $display("FAIL ovf_pop_valid[%0d]: got %b, required %b", k, valid_o, k < 4);
            else n_pass++;
        end
        n_checks++;
        if (overflow_o !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", overflow_o);
        else n_pass++;
        idle_sync();
        wait_drain(5);
    endtask

    task automatic test_full_pushpop();
        logic [7:0] b;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        ready_i = 1'b0;
        idle_sync();
        for (int i = 0; i < 4; i++) begin
            b = 8'h10 + 8'(i);
            send_frame(b, 1'b1, 1'b1);
        end
        fork
            send_frame(8'h14, 1'b1, 1'b1);
            begin
                repeat (78) @(posedge clk);
                #1;
                ready_i = 1'b1;
                @(posedge clk);
                #1;
                ready_i = 1'b0;
            end
        join
        n_checks++;
        if (overflow_o !== 1'b0) $display("FAIL full_pushpop_ovf: got %b, required 0", overflow_o);
        else n_pass++;
        n_checks++;
        if (valid_o !== 1'b1) $display("FAIL full_pushpop_valid: got %b, required 1", valid_o);
        else n_pass++;
        ready_i = 1'b1;
        wait_drain(20);
    endtask

    task automatic test_reset_midframe();
        logic rb_before = 1'b0;
        ready_i = 1'b0;
        idle_sync();
        send_frame(8'hC3, 1'b1, 1'b0);
        n_checks++;
        if ({valid_o, byte_o} !== 9'h1C3) $display("FAIL pre_reset_head: got %b %02h, required 1 c3", valid_o, byte_o);
        else n_pass++;
        fork
            send_frame(8'h00, 1'b1, 1'b0);
            begin
                repeat (45) @(posedge clk);
                #1;
                rb_before = reading_byte_o;
                rst_n = 1'b0;
                #1;
                n_checks++;
                if ({byte_o, valid_o, reading_byte_o, frame_err_o, overflow_o} !== 12'h000)
                    $display("FAIL midframe_reset_outputs: got %03h, required 000",
                             {byte_o, valid_o, reading_byte_o, frame_err_o, overflow_o});
                else n_pass++;
            end
        join
        n_checks++;
        if (rb_before !== 1'b1) $display("FAIL midframe_busy: got %b, required 1", rb_before);
        else n_pass++;
        exp_q.delete();
        idle_sync();
        rst_n = 1'b1;
        idle_sync();
        n_checks++;
        if ({valid_o, reading_byte_o} !== 2'b00)
            $display("FAIL after_release: got %b, required 00", {valid_o, reading_byte_o});
        else n_pass++;
        ready_i = 1'b1;
        send_frame(8'hFF, 1'b1, 1'b1);
        wait_drain(20);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_overflow();
        test_full_pushpop();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
